// File: rtl/onchip_mem_pipelined_if.sv
// Avalon-MM pipelined slave bundle for onchip_mem_pipelined.
// Also carries clken/reset_req, and init_done, which travel with the bus.
interface onchip_mem_pipelined_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    clken;
  logic                    reset_req;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;
  logic                    init_done;

  modport master (
    output address, chipselect, read, write, writedata, byteenable, clken, reset_req,
    input  readdata, readdatavalid, waitrequest, init_done
  );

  modport slave (
    input  address, chipselect, read, write, writedata, byteenable, clken, reset_req,
    output readdata, readdatavalid, waitrequest, init_done
  );
endinterface

// File: rtl/onchip_mem_pipelined.sv
// Single-port on-chip RAM behind an Avalon-MM pipelined slave: byte lanes,
// optional output register, read/readdatavalid signalling and optional clear sweep.
module onchip_mem_pipelined #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 15,
  parameter int                    OUT_REG        = 0,
  parameter int                    CLEAR_ON_RESET = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input logic                    clk,
  input logic                    reset,
  onchip_mem_pipelined_if.slave  s
);
  // state    | meaning
  // ST_CLEAR | sweeping CLEAR_VALUE into every word, bus held off
  // ST_READY | contents defined, requests accepted whenever enabled
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NLANES = DATA_WIDTH / 8;

  typedef enum logic [0:0] {ST_CLEAR, ST_READY} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  r_init_done;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_en;
  logic                  w_accept;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [NLANES-1:0]     w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_en          = s.clken & ~s.reset_req;
  assign s.waitrequest = (r_state == ST_CLEAR) | ~w_en;
  assign w_accept      = s.chipselect & (s.read | s.write) & ~s.waitrequest;
  assign w_wr_acc      = w_accept & s.write;
  // a combined read+write request performs only the write
  assign w_rd_acc      = w_accept & s.read & ~s.write;
  assign s.init_done   = r_init_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_addr  <= '0;
      r_init_done <= (CLEAR_ON_RESET == 0);
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_addr == '1) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: begin
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  // the sweep owns the write port while clearing and ignores clken/reset_req
  always_comb begin
    w_we    = '0;
    w_waddr = s.address;
    w_wdata = s.writedata;
    if (r_state == ST_CLEAR && !reset) begin
      w_we    = '1;
      w_waddr = r_clr_addr;
      w_wdata = CLEAR_VALUE;
    end else if (w_wr_acc) begin
      w_we = s.byteenable;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (w_we[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
    end
  end

  generate
    if (OUT_REG == 0) begin : g_lat1
      logic [DATA_WIDTH-1:0] r_q;
      logic                  r_vld;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_q   <= '0;
          r_vld <= 1'b0;
        end else if (w_en) begin
          r_vld <= w_rd_acc;
          if (w_rd_acc) r_q <= r_mem[s.address];
        end else begin
          r_vld <= 1'b0;
        end
      end

      assign s.readdata      = r_q;
      assign s.readdatavalid = r_vld;
    end else begin : g_lat2
      logic [DATA_WIDTH-1:0] r_s1_q;
      logic                  r_s1_vld;
      logic [DATA_WIDTH-1:0] r_q;
      logic                  r_vld;

      // stage 1 holds through a stall so the read is delivered once en returns
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1_q   <= '0;
          r_s1_vld <= 1'b0;
          r_q      <= '0;
          r_vld    <= 1'b0;
        end else if (w_en) begin
          r_s1_vld <= w_rd_acc;
          if (w_rd_acc) r_s1_q <= r_mem[s.address];
          r_vld <= r_s1_vld;
          if (r_s1_vld) r_q <= r_s1_q;
        end else begin
          r_vld <= 1'b0;
        end
      end

      assign s.readdata      = r_q;
      assign s.readdatavalid = r_vld;
    end
  endgenerate
endmodule

// File: tb/tb_onchip_mem_pipelined.sv
// Directed bench: 32-bit x 16-word memory, one instance with output register and
// clear sweep, one with latency 1 and no sweep.
module tb_onchip_mem_pipelined;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  onchip_mem_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();
  onchip_mem_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();

  onchip_mem_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hA5A5A5A5)
  ) u_dut (.clk(clk), .reset(rst), .s(bus));

  onchip_mem_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0),
    .CLEAR_ON_RESET(0), .CLEAR_VALUE(32'h0)
  ) u_dut0 (.clk(clk), .reset(rst), .s(bus0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.chipselect = 1'b1;
    bus.read       = 1'b0;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
    cyc();
    idle();
  endtask

  task automatic rd_word(input logic [3:0] a, output logic [31:0] d, output int lat);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b0;
    bus.address    = a;
    cyc();
    idle();
    lat = 0;
    d   = '0;
    for (int k = 1; k <= 8; k++) begin
      if (lat == 0) begin
        @(negedge clk);
        if (bus.readdatavalid) begin
          lat = k;
          d   = bus.readdata;
        end
        cyc();
      end
    end
  endtask

  // counts waitrequest cycles until init_done rises; stops at that cycle's negedge
  task automatic count_wait(output int n, output bit done);
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!done) begin
        @(negedge clk);
        if (bus.init_done) done = 1'b1;
        else begin
          if (bus.waitrequest) n++;
          cyc();
        end
      end
    end
  endtask

  logic [31:0] d;
  int          lat;
  int          n;
  bit          done;
  logic [7:0]  lv;
  logic [31:0] ld [8];

  initial begin
    rst = 1'b1;
    idle();
    bus.address = '0; bus.writedata = '0; bus.byteenable = '1;
    bus.clken = 1'b1; bus.reset_req = 1'b0;
    bus0.chipselect = 1'b0; bus0.read = 1'b0; bus0.write = 1'b0;
    bus0.address = '0; bus0.writedata = '0; bus0.byteenable = '1;
    bus0.clken = 1'b1; bus0.reset_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    // first cycle after reset
    #2;
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_rdvalid", {31'b0, bus.readdatavalid}, 32'h0);
    check("rst_init_done", {31'b0, bus.init_done}, 32'h0);
    check("dut0_init_done", {31'b0, bus0.init_done}, 32'h1);
    check("dut0_waitreq", {31'b0, bus0.waitrequest}, 32'h0);
    count_wait(n, done);
    check("clr_wait_cycles", n, 16);
    check("clr_done", {31'b0, done}, 32'h1);
    check("clr_waitreq_after", {31'b0, bus.waitrequest}, 32'h0);
    cyc();

    for (int a = 0; a < 16; a++) begin
      rd_word(4'(a), d, lat);
      check($sformatf("clr_rd_%0d", a), d, 32'hA5A5A5A5);
      if (a == 0) check("clr_rd_lat", lat, 2);
    end

    // latency-1 instance: write, read-after-write, stall in the delivery cycle
    for (int c = 0; c < 6; c++) begin
      bus0.chipselect = 1'b0; bus0.read = 1'b0; bus0.write = 1'b0; bus0.clken = 1'b1;
      case (c)
        0: begin
          bus0.chipselect = 1'b1; bus0.write = 1'b1; bus0.address = 4'd9;
          bus0.writedata = 32'h12345678; bus0.byteenable = 4'hF;
        end
        1, 2: begin
          bus0.chipselect = 1'b1; bus0.read = 1'b1; bus0.address = 4'd9;
        end
        3: bus0.clken = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      lv[c] = bus0.readdatavalid;
      ld[c] = bus0.readdata;
      cyc();
    end
    bus0.clken = 1'b1;
    check("l1_pulses", {26'b0, lv[5:0]}, 32'h0C);
    check("l1_data_c2", ld[2], 32'h12345678);
    check("l1_data_c3", ld[3], 32'h12345678);
    check("l1_hold_c5", ld[5], 32'h12345678);

    // byte enables
    wr(4'd3, 32'h11223344, 4'b1111);
    wr(4'd3, 32'hAABBCCDD, 4'b0101);
    rd_word(4'd3, d, lat);
    check("be_data", d, 32'h11BB33DD);
    check("be_lat", lat, 2);

    // back-to-back reads
    for (int a = 0; a < 4; a++) wr(4'(a), 32'h10 + 32'(a), 4'hF);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 4'(c);
      end else idle();
      @(negedge clk);
      lv[c] = bus.readdatavalid;
      ld[c] = bus.readdata;
      cyc();
    end
    check("tp_pulses", {24'b0, lv}, 32'h3C);
    for (int c = 2; c < 6; c++) check($sformatf("tp_data_%0d", c), ld[c], 32'h10 + 32'(c - 2));

    // stall with output register
    wr(4'd5, 32'hCAFEF00D, 4'hF);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      idle();
      bus.clken = !(c >= 1 && c <= 3);
      if (c == 0) begin
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 4'd5;
      end
      @(negedge clk);
      if (c >= 1 && c <= 3 && bus.waitrequest) n++;
      lv[c] = bus.readdatavalid;
      ld[c] = bus.readdata;
      cyc();
    end
    bus.clken = 1'b1;
    check("stall_waitreq", n, 3);
    check("stall_pulses", {24'b0, lv}, 32'h20);
    check("stall_data", ld[5], 32'hCAFEF00D);

    // reset_req gates waitrequest combinationally
    bus.reset_req = 1'b1;
    #1;
    check("rreq_waitreq_hi", {31'b0, bus.waitrequest}, 32'h1);
    bus.reset_req = 1'b0;
    #1;
    check("rreq_waitreq_lo", {31'b0, bus.waitrequest}, 32'h0);
    cyc();

    // read and write together
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) begin
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b1; bus.address = 4'd2;
        bus.writedata = 32'h55; bus.byteenable = 4'hF;
      end else if (c == 1) begin
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 4'd2;
      end
      @(negedge clk);
      lv[c] = bus.readdatavalid;
      ld[c] = bus.readdata;
      cyc();
    end
    check("rw_pulses", {26'b0, lv[5:0]}, 32'h08);
    check("rw_data", ld[3], 32'h55);

    // reset in the cycle after a read is accepted
    for (int c = 0; c < 6; c++) begin
      idle();
      rst = (c == 1);
      if (c == 0) begin
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 4'd2;
      end
      @(negedge clk);
      lv[c] = bus.readdatavalid;
      ld[c] = bus.readdata;
      cyc();
    end
    rst = 1'b0;
    check("rstrd_pulses", {26'b0, lv[5:0]}, 32'h00);
    check("rstrd_readdata", ld[2], 32'h0);

    // sweep began at c=2, so c=9 is the cycle writing address 7
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    count_wait(n, done);
    check("restart_wait_cycles", n, 16);
    check("restart_done", {31'b0, done}, 32'h1);
    cyc();
    rd_word(4'd2, d, lat);
    check("restart_rd_2", d, 32'hA5A5A5A5);
    rd_word(4'd3, d, lat);
    check("restart_rd_3", d, 32'hA5A5A5A5);
    rd_word(4'd15, d, lat);
    check("restart_rd_15", d, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
